// File: rtl/matrix_catalog_reporter_pkg.sv
// rtl/matrix_catalog_reporter_pkg.sv - shared ASCII codes, report modes and FSM states
package matrix_catalog_reporter_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_X     = 8'h78;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_NL    = 8'h0A;
   localparam logic [7:0] ASCII_T     = 8'h54;

   localparam int BCD_DIGITS = 5;

   typedef enum logic [1:0] {
      MODE_LIST  = 2'd0,
      MODE_TOTAL = 2'd1,
      MODE_ROW   = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SCAN_ADDR,
      ST_SCAN_WAIT,
      ST_SCAN_EVAL,
      ST_EMIT_ROW,
      ST_EMIT_X,
      ST_EMIT_COL,
      ST_EMIT_COLON,
      ST_EMIT_NUM,
      ST_EMIT_NL,
      ST_NEXT,
      ST_TOT_T,
      ST_TOT_COLON,
      ST_FINISH
   } state_t;

   // Index of the most significant non-zero BCD digit; 0 when the value is zero.
   function automatic logic [2:0] top_digit(input logic [4*BCD_DIGITS-1:0] bcd);
      top_digit = 3'd0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] != 4'd0) top_digit = 3'(i);
      end
   endfunction

endpackage

// File: rtl/matrix_catalog_reporter_bin2dec_serial.sv
// rtl/matrix_catalog_reporter_bin2dec_serial.sv - serial double-dabble binary to 5-digit BCD
module bin2dec_serial
   import matrix_catalog_reporter_pkg::*;
#(
   parameter int TOT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   input  logic                      start,
   input  logic [TOT_WIDTH-1:0]      value,
   output logic                      busy,
   output logic                      done,
   output logic [4*BCD_DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(TOT_WIDTH + 1);

   logic [TOT_WIDTH-1:0]    bin;
   logic [CW-1:0]           bits_left;
   logic [4*BCD_DIGITS-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd       <= '0;
         bin       <= '0;
         bits_left <= '0;
      end else if (clr) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd       <= '0;
         bin       <= '0;
         bits_left <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            bin       <= value;
            bcd       <= '0;
            bits_left <= CW'(TOT_WIDTH);
            busy      <= 1'b1;
         end else if (busy) begin
            bcd       <= {adj[4*BCD_DIGITS-2:0], bin[TOT_WIDTH-1]};
            bin       <= bin << 1;
            bits_left <= bits_left - 1'b1;
            if (bits_left == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/matrix_catalog_reporter.sv
// rtl/matrix_catalog_reporter.sv - scans storage size classes and streams an ASCII catalogue
module matrix_catalog_reporter
   import matrix_catalog_reporter_pkg::*;
#(
   parameter int MAX_ROWS  = 5,
   parameter int MAX_COLS  = 5,
   parameter int DIM_WIDTH = 3,
   parameter int CNT_WIDTH = 5,
   parameter int RD_LAT    = 2,
   parameter int TOT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic [DIM_WIDTH-1:0] flt_row,
   input  logic [4:0]           pick_k,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic [DIM_WIDTH-1:0] qry_row,
   output logic [DIM_WIDTH-1:0] qry_col,
   input  logic [CNT_WIDTH-1:0] qry_cnt,
   output logic                 pick_valid,
   output logic [DIM_WIDTH-1:0] pick_row,
   output logic [DIM_WIDTH-1:0] pick_col,
   output logic [CNT_WIDTH-1:0] pick_cnt
);

   localparam int WW  = $clog2(RD_LAT + 1);
   localparam int TW1 = TOT_WIDTH + 1;

   state_t                  state;
   mode_t                   mode_r;
   logic [4:0]              pick_k_r;
   logic [TOT_WIDTH-1:0]    total;
   logic [6:0]              rc;
   logic [DIM_WIDTH-1:0]    sh_row;
   logic [DIM_WIDTH-1:0]    sh_col;
   logic [CNT_WIDTH-1:0]    sh_cnt;
   logic [CNT_WIDTH-1:0]    cur_cnt;
   logic [WW-1:0]           wait_cnt;
   logic                    in_tot;
   logic                    armed;
   logic                    conv_start;
   logic                    num_sending;
   logic [2:0]              dig_idx;

   logic                    conv_busy;
   logic                    conv_done;
   logic [4*BCD_DIGITS-1:0] conv_bcd;
   logic [TOT_WIDTH-1:0]    conv_value;
   logic [TW1-1:0]          sum;
   logic [2:0]              top_idx;
   logic [2:0]              nxt_idx;
   logic [3:0]              top_dig;
   logic [3:0]              nxt_dig;
   logic                    flt_ok;

   assign conv_value = in_tot ? total : TOT_WIDTH'(cur_cnt);
   assign sum        = {1'b0, total} + TW1'(qry_cnt);
   assign top_idx    = top_digit(conv_bcd);
   assign nxt_idx    = dig_idx - 3'd1;
   assign top_dig    = conv_bcd[{top_idx, 2'b00} +: 4];
   assign nxt_dig    = conv_bcd[{nxt_idx, 2'b00} +: 4];
   assign flt_ok     = (flt_row != '0) && (flt_row <= DIM_WIDTH'(MAX_ROWS));

   bin2dec_serial #(.TOT_WIDTH(TOT_WIDTH)) u_bin2dec (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (abort),
      .start (conv_start),
      .value (conv_value),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         tx_valid    <= 1'b0;
         tx_data     <= '0;
         qry_row     <= DIM_WIDTH'(1);
         qry_col     <= DIM_WIDTH'(1);
         pick_valid  <= 1'b0;
         pick_row    <= '0;
         pick_col    <= '0;
         pick_cnt    <= '0;
         mode_r      <= MODE_LIST;
         pick_k_r    <= '0;
         total       <= '0;
         rc          <= '0;
         sh_row      <= '0;
         sh_col      <= '0;
         sh_cnt      <= '0;
         cur_cnt     <= '0;
         wait_cnt    <= '0;
         in_tot      <= 1'b0;
         armed       <= 1'b1;
         conv_start  <= 1'b0;
         num_sending <= 1'b0;
         dig_idx     <= '0;
      end else begin
         done       <= 1'b0;
         conv_start <= 1'b0;
         if (abort && state != ST_IDLE) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            tx_valid    <= 1'b0;
            num_sending <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (!start) begin
                     armed <= 1'b1;
                  end else if (armed && !abort) begin
                     armed    <= 1'b0;
                     busy     <= 1'b1;
                     mode_r   <= (mode == MODE_RSVD) ? MODE_LIST : mode_t'(mode);
                     pick_k_r <= pick_k;
                     total    <= '0;
                     rc       <= '0;
                     sh_row   <= '0;
                     sh_col   <= '0;
                     sh_cnt   <= '0;
                     in_tot   <= 1'b0;
                     qry_row  <= (mode == MODE_ROW) ? flt_row : DIM_WIDTH'(1);
                     qry_col  <= DIM_WIDTH'(1);
                     // An out-of-range filter row has nothing to scan: go straight to the trailer.
                     if (mode == MODE_ROW && !flt_ok) begin
                        in_tot   <= 1'b1;
                        tx_data  <= ASCII_T;
                        tx_valid <= 1'b1;
                        state    <= ST_TOT_T;
                     end else begin
                        state <= ST_SCAN_ADDR;
                     end
                  end
               end
               ST_SCAN_ADDR: begin
                  wait_cnt <= WW'(1);
                  state    <= ST_SCAN_WAIT;
               end
               ST_SCAN_WAIT: begin
                  if (wait_cnt == WW'(RD_LAT)) state <= ST_SCAN_EVAL;
                  else wait_cnt <= wait_cnt + 1'b1;
               end
               ST_SCAN_EVAL: begin
                  cur_cnt <= qry_cnt;
                  if (qry_cnt != '0) begin
                     total <= sum[TOT_WIDTH] ? '1 : sum[TOT_WIDTH-1:0];
                     rc    <= rc + 7'd1;
                     if (rc + 7'd1 == {2'b00, pick_k_r}) begin
                        sh_row <= qry_row;
                        sh_col <= qry_col;
                        sh_cnt <= qry_cnt;
                     end
                  end
                  if (qry_cnt != '0 && mode_r != MODE_TOTAL) begin
                     tx_data  <= ASCII_ZERO + 8'(qry_row);
                     tx_valid <= 1'b1;
                     state    <= ST_EMIT_ROW;
                  end else begin
                     state <= ST_NEXT;
                  end
               end
               ST_EMIT_ROW: if (tx_ready) begin
                  tx_data <= ASCII_X;
                  state   <= ST_EMIT_X;
               end
               ST_EMIT_X: if (tx_ready) begin
                  tx_data <= ASCII_ZERO + 8'(qry_col);
                  state   <= ST_EMIT_COL;
               end
               ST_EMIT_COL: if (tx_ready) begin
                  tx_data <= ASCII_COLON;
                  state   <= ST_EMIT_COLON;
               end
               ST_TOT_T: if (tx_ready) begin
                  tx_data <= ASCII_COLON;
                  state   <= ST_TOT_COLON;
               end
               ST_EMIT_COLON, ST_TOT_COLON: if (tx_ready) begin
                  tx_valid    <= 1'b0;
                  conv_start  <= 1'b1;
                  num_sending <= 1'b0;
                  state       <= ST_EMIT_NUM;
               end
               ST_EMIT_NUM: begin
                  if (!num_sending) begin
                     if (conv_done && !conv_busy) begin
                        num_sending <= 1'b1;
                        dig_idx     <= top_idx;
                        tx_data     <= ASCII_ZERO + {4'h0, top_dig};
                        tx_valid    <= 1'b1;
                     end
                  end else if (tx_ready) begin
                     if (dig_idx == 3'd0) begin
                        num_sending <= 1'b0;
                        tx_data     <= ASCII_NL;
                        state       <= ST_EMIT_NL;
                     end else begin
                        dig_idx <= nxt_idx;
                        tx_data <= ASCII_ZERO + {4'h0, nxt_dig};
                     end
                  end
               end
               ST_EMIT_NL: if (tx_ready) begin
                  tx_valid <= 1'b0;
                  if (in_tot) begin
                     done <= 1'b1;
                     if (pick_k_r != 5'd0 && {2'b00, pick_k_r} <= rc) begin
                        pick_valid <= 1'b1;
                        pick_row   <= sh_row;
                        pick_col   <= sh_col;
                        pick_cnt   <= sh_cnt;
                     end else begin
                        pick_valid <= 1'b0;
                     end
                     state <= ST_FINISH;
                  end else begin
                     state <= ST_NEXT;
                  end
               end
               ST_NEXT: begin
                  if (qry_col == DIM_WIDTH'(MAX_COLS)) begin
                     if (mode_r == MODE_ROW || qry_row == DIM_WIDTH'(MAX_ROWS)) begin
                        in_tot   <= 1'b1;
                        tx_data  <= ASCII_T;
                        tx_valid <= 1'b1;
                        state    <= ST_TOT_T;
                     end else begin
                        qry_row <= qry_row + DIM_WIDTH'(1);
                        qry_col <= DIM_WIDTH'(1);
                        state   <= ST_SCAN_ADDR;
                     end
                  end else begin
                     qry_col <= qry_col + DIM_WIDTH'(1);
                     state   <= ST_SCAN_ADDR;
                  end
               end
               ST_FINISH: begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_matrix_catalog_reporter.sv
// tb/tb_matrix_catalog_reporter.sv - directed self-checking bench for matrix_catalog_reporter
module tb_matrix_catalog_reporter;

   localparam int RD_LAT = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [2:0] flt_row = 3'd0;
   logic [4:0] pick_k = 5'd0;
   logic       abort = 1'b0;
   logic       tx_ready;
   logic       busy, done, tx_valid, pick_valid;
   logic [7:0] tx_data;
   logic [2:0] qry_row, qry_col, pick_row, pick_col;
   logic [4:0] qry_cnt, pick_cnt;

   int   n_tests = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   ready_mode = 0;
   logic rnd_bit = 1'b1;
   byte  rx_q[$];

   logic [4:0] mem  [0:7][0:7];
   logic [4:0] pipe [0:RD_LAT-1];

   always #5 clk = ~clk;

   matrix_catalog_reporter #(
      .MAX_ROWS(5), .MAX_COLS(5), .DIM_WIDTH(3), .CNT_WIDTH(5), .RD_LAT(RD_LAT), .TOT_WIDTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .flt_row(flt_row),
      .pick_k(pick_k), .abort(abort), .busy(busy), .done(done), .tx_valid(tx_valid),
      .tx_data(tx_data), .tx_ready(tx_ready), .qry_row(qry_row), .qry_col(qry_col),
      .qry_cnt(qry_cnt), .pick_valid(pick_valid), .pick_row(pick_row),
      .pick_col(pick_col), .pick_cnt(pick_cnt)
   );

   // Storage model: count appears RD_LAT cycles after the query address changes.
   assign qry_cnt = pipe[RD_LAT-1];
   always @(posedge clk) begin
      pipe[0] <= mem[qry_row][qry_col];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign tx_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? rnd_bit : 1'b0;
   always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

   always @(posedge clk) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_mem(input logic [4:0] fill);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            mem[r][c] = (r >= 1 && r <= 5 && c >= 1 && c <= 5) ? fill : 5'd0;
   endtask

   function automatic int first_diff(input string exp);
      int n;
      first_diff = -1;
      n = (exp.len() > rx_q.size()) ? exp.len() : rx_q.size();
      for (int i = 0; i < n; i++)
         if (first_diff < 0 && (i >= exp.len() || i >= rx_q.size() || rx_q[i] != exp[i]))
            first_diff = i;
   endfunction

   task automatic run(input string tag, input logic [1:0] m, input logic [2:0] f,
                      input logic [4:0] k, input string exp, input logic pv,
                      input logic [2:0] pr, input logic [2:0] pc, input logic [4:0] pn);
      int d0, cyc;
      rx_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      mode = m; flt_row = f; pick_k = k; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_finished"}, 32'(busy), 0);
      chk({tag, "_bytes_first_diff"}, first_diff(exp), -1);
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      chk({tag, "_pick_valid"}, 32'(pick_valid), 32'(pv));
      chk({tag, "_pick"}, 32'({pick_row, pick_col, pick_cnt}), 32'({pr, pc, pn}));
   endtask

   initial begin
      int d0, cyc;
      set_mem(5'd0);
      repeat (3) @(negedge clk);
      chk("reset_ctrl", 32'({busy, done, tx_valid, pick_valid}), 0);
      chk("reset_data", 32'({tx_data, pick_row, pick_col, pick_cnt}), 0);
      chk("reset_qry", 32'({qry_row, qry_col}), 32'({3'd1, 3'd1}));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      mem[2][3] = 5'd2;
      mem[5][5] = 5'd12;
      run("list", 2'd0, 3'd0, 5'd2, "2x3:2\n5x5:12\nT:14\n", 1'b1, 3'd5, 3'd5, 5'd12);
      run("total", 2'd1, 3'd0, 5'd1, "T:14\n", 1'b1, 3'd2, 3'd3, 5'd2);
      run("row5", 2'd2, 3'd5, 5'd1, "5x5:12\nT:12\n", 1'b1, 3'd5, 3'd5, 5'd12);
      run("row7", 2'd2, 3'd7, 5'd1, "T:0\n", 1'b0, 3'd5, 3'd5, 5'd12);

      set_mem(5'd0);
      run("empty", 2'd0, 3'd0, 5'd3, "T:0\n", 1'b0, 3'd5, 3'd5, 5'd12);

      set_mem(5'd31);
      run("full_total", 2'd1, 3'd0, 5'd25, "T:775\n", 1'b1, 3'd5, 3'd5, 5'd31);

      set_mem(5'd0);
      mem[2][3] = 5'd2;
      mem[5][5] = 5'd12;
      ready_mode = 1;
      run("rand_ready", 2'd0, 3'd0, 5'd2, "2x3:2\n5x5:12\nT:14\n", 1'b1, 3'd5, 3'd5, 5'd12);

      ready_mode = 0;
      rx_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      mode = 2'd0; pick_k = 5'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (rx_q.size() < 2 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_reached_2x", rx_q.size(), 2);
      ready_mode = 2;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_tx_valid", 32'(tx_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      repeat (5) @(negedge clk);
      chk("abort_bytes_first_diff", first_diff("2x"), -1);
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_pick", 32'({pick_valid, pick_row, pick_col, pick_cnt}),
          32'({1'b1, 3'd5, 3'd5, 5'd12}));
      ready_mode = 0;
      run("after_abort_mode3", 2'd3, 3'd0, 5'd1, "2x3:2\n5x5:12\nT:14\n", 1'b1, 3'd2, 3'd3, 5'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
